fe_fetch_queue: RTL



---
 rtl/fe_fetch_queue_if.sv | 35 +++
 rtl/fe_fetch_queue.sv | 132 +++++++++++++
 2 files changed

// File: rtl/fe_fetch_queue_if.sv
// Fetch-queue bus: instruction memory port, redirect input, decode handshake and status.
// master = fetch queue, slave = surrounding core / testbench.
interface fe_fetch_queue_if #(
    parameter int DBITS    = 32,
    parameter int INSTBITS = 32,
    parameter int QDEPTH   = 4
);
    // Decode handshake: an entry moves only in a cycle where out_valid and
    // de_ready are both high and redirect_valid is low.
    logic [DBITS-1:0]            imem_addr;
    logic [INSTBITS-1:0]         imem_data;
    logic                        redirect_valid;
    logic [DBITS-1:0]            redirect_pc;
    logic                        de_ready;
    logic                        out_valid;
    logic [INSTBITS-1:0]         out_inst;
    logic [DBITS-1:0]            out_pc;
    logic [DBITS-1:0]            out_pcplus;
    logic [DBITS-1:0]            out_inst_count;
    logic [$clog2(QDEPTH):0]     q_occupancy;
    logic [DBITS-1:0]            perf_stall_cycles;
    logic [DBITS-1:0]            perf_flushes;

    modport master (
        output imem_addr, out_valid, out_inst, out_pc, out_pcplus, out_inst_count,
               q_occupancy, perf_stall_cycles, perf_flushes,
        input  imem_data, redirect_valid, redirect_pc, de_ready
    );

    modport slave (
        input  imem_addr, out_valid, out_inst, out_pc, out_pcplus, out_inst_count,
               q_occupancy, perf_stall_cycles, perf_flushes,
        output imem_data, redirect_valid, redirect_pc, de_ready
    );
endinterface

// File: rtl/fe_fetch_queue.sv
// Fetch front-end: owns the PC, fetches one instruction per cycle into a QDEPTH FIFO.
// Optional performance counters are enabled with `define FE_FETCH_QUEUE_PERF_EN.
module fe_fetch_queue #(
    parameter int               DBITS    = 32,
    parameter int               INSTBITS = 32,
    parameter int               QDEPTH   = 4,
    parameter logic [DBITS-1:0] STARTPC  = 32'h100,
    parameter int               INSTSIZE = 4
) (
    input  logic                clk,
    input  logic                reset,
    fe_fetch_queue_if.master    bus
);
    localparam int                QBITS = $clog2(QDEPTH);
    localparam logic [QBITS:0]    QFULL = (QBITS+1)'(QDEPTH);
    localparam logic [DBITS-1:0]  STEP  = DBITS'(INSTSIZE);

    logic [DBITS-1:0]    pc_q, pc_d;
    logic [DBITS-1:0]    cnt_q, cnt_d;
    logic [QBITS-1:0]    wr_ptr_q, wr_ptr_d;
    logic [QBITS-1:0]    rd_ptr_q, rd_ptr_d;
    logic [QBITS:0]      occ_q, occ_d;

    logic [INSTBITS-1:0] inst_mem_q   [QDEPTH];
    logic [DBITS-1:0]    pc_mem_q     [QDEPTH];
    logic [DBITS-1:0]    pcplus_mem_q [QDEPTH];
    logic [DBITS-1:0]    cnt_mem_q    [QDEPTH];

    logic out_valid;
    logic pop;
    logic push;
    logic full;

    assign out_valid = (occ_q != '0);
    assign full      = (occ_q == QFULL);
    assign pop       = out_valid & bus.de_ready & ~bus.redirect_valid;
    // A full queue can still take a fetch when the head leaves in the same cycle.
    assign push      = ~bus.redirect_valid & (~full | pop);

    always_comb begin
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (bus.redirect_valid) begin
            pc_d     = bus.redirect_pc;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + STEP;
                cnt_d    = cnt_q + 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= STARTPC;
            cnt_q    <= DBITS'(1);
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted in occ_q.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            inst_mem_q[wr_ptr_q]   <= bus.imem_data;
            pc_mem_q[wr_ptr_q]     <= pc_q;
            pcplus_mem_q[wr_ptr_q] <= pc_q + STEP;
            cnt_mem_q[wr_ptr_q]    <= cnt_q;
        end
    end

    assign bus.imem_addr      = pc_q;
    assign bus.out_valid      = out_valid;
    assign bus.q_occupancy    = occ_q;
    assign bus.out_inst       = out_valid ? inst_mem_q[rd_ptr_q]   : '0;
    assign bus.out_pc         = out_valid ? pc_mem_q[rd_ptr_q]     : '0;
    assign bus.out_pcplus     = out_valid ? pcplus_mem_q[rd_ptr_q] : '0;
    assign bus.out_inst_count = out_valid ? cnt_mem_q[rd_ptr_q]    : '0;

`ifdef FE_FETCH_QUEUE_PERF_EN
    logic [DBITS-1:0] stall_q, stall_d;
    logic [DBITS-1:0] flush_q, flush_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (bus.redirect_valid) begin
            flush_d = flush_q + 1'b1;
        end else if (full && !pop) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign bus.perf_stall_cycles = stall_q;
    assign bus.perf_flushes      = flush_q;
`else
    assign bus.perf_stall_cycles = '0;
    assign bus.perf_flushes      = '0;
`endif
endmodule
